// File: rtl/distance_fare_meter.sv
// Taxi meter distance/fare accumulator, clocked by the 10 m wheel pulse.
// Counts pulses into BCD kilometres and accumulates a saturating BCD fare.
module distance_fare_meter (
    input  logic        ten_meter_pulse,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] distance_fare_per_pulse,
    input  logic [11:0] s_fare,
    output logic [7:0]  distance_bcd,
    output logic [15:0] distance_fare_bcd
);

    logic [6:0]  sub_q, sub_d;
    logic [7:0]  km_q,  km_d;
    logic [15:0] acc_q, acc_d;
    logic        full;
    logic [16:0] acc_sum;
    logic [16:0] out_sum;

    // Four-digit packed BCD add; bit 16 is the carry out of the top digit.
    function automatic logic [16:0] bcd_add4(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [4:0]  s;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            if (s > 5'd9) begin
                r[4*i +: 4] = 4'(s - 5'd10);
                c = 1'b1;
            end else begin
                r[4*i +: 4] = s[3:0];
                c = 1'b0;
            end
        end
        return {c, r};
    endfunction

    assign full    = (km_q == 8'h99);
    assign acc_sum = bcd_add4(acc_q, {4'h0, distance_fare_per_pulse});
    assign out_sum = bcd_add4(acc_q, {4'h0, s_fare});

    always_comb begin
        sub_d = sub_q;
        km_d  = km_q;
        acc_d = acc_q;
        if (en && !full) begin
            if (sub_q == 7'd99) begin
                sub_d = '0;
                if (km_q[3:0] == 4'd9) begin
                    km_d = {km_q[7:4] + 4'd1, 4'd0};
                end else begin
                    km_d = {km_q[7:4], km_q[3:0] + 4'd1};
                end
            end else begin
                sub_d = sub_q + 7'd1;
            end
            acc_d = acc_sum[16] ? 16'h9999 : acc_sum[15:0];
        end
    end

    always_ff @(posedge ten_meter_pulse or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= '0;
            km_q  <= '0;
            acc_q <= '0;
        end else begin
            sub_q <= sub_d;
            km_q  <= km_d;
            acc_q <= acc_d;
        end
    end

    assign distance_bcd      = km_q;
    assign distance_fare_bcd = out_sum[16] ? 16'h9999 : out_sum[15:0];

endmodule

// File: tb/tb_distance_fare_meter.sv
// Table-driven bench for distance_fare_meter with an expected-value queue.
module tb_distance_fare_meter;

    logic        ten_meter_pulse;
    logic        rst_n;
    logic        en;
    logic [11:0] distance_fare_per_pulse;
    logic [11:0] s_fare;
    logic [7:0]  distance_bcd;
    logic [15:0] distance_fare_bcd;

    distance_fare_meter dut (
        .ten_meter_pulse         (ten_meter_pulse),
        .rst_n                   (rst_n),
        .en                      (en),
        .distance_fare_per_pulse (distance_fare_per_pulse),
        .s_fare                  (s_fare),
        .distance_bcd            (distance_bcd),
        .distance_fare_bcd       (distance_fare_bcd)
    );

    typedef struct {
        bit          do_rst;
        bit          en;
        logic [11:0] per;
        logic [11:0] sf;
        int unsigned n;
        logic [7:0]  d;
        logic [15:0] f;
        string       name;
    } vec_t;

    typedef struct {
        logic [7:0]  d;
        logic [15:0] f;
        string       name;
    } exp_t;

    localparam int unsigned NVEC = 19;
    vec_t tbl [NVEC];
    exp_t sbq [$];
    int   tests;
    int   fails;

    task automatic pulse(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            #5 ten_meter_pulse = 1'b1;
            #5 ten_meter_pulse = 1'b0;
        end
    endtask

    task automatic expect_now(input logic [7:0] d, input logic [15:0] f, input string name);
        exp_t e;
        e.d = d;
        e.f = f;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic check_next();
        exp_t e;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e = sbq.pop_front();
            tests++;
            if (distance_bcd !== e.d) begin
                fails++;
                $display("FAIL %s dist: got %h want %h", e.name, distance_bcd, e.d);
            end
            tests++;
            if (distance_fare_bcd !== e.f) begin
                fails++;
                $display("FAIL %s fare: got %h want %h", e.name, distance_fare_bcd, e.f);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ten_meter_pulse = 1'b0;
        rst_n = 1'b0;
        en = 1'b0;
        distance_fare_per_pulse = 12'h003;
        s_fare = 12'h300;

        tbl[0]  = '{1'b1, 1'b0, 12'h003, 12'h300,    0, 8'h00, 16'h0300, "reset"};
        tbl[1]  = '{1'b0, 1'b0, 12'h003, 12'h300,    5, 8'h00, 16'h0300, "en_gate"};
        tbl[2]  = '{1'b0, 1'b1, 12'h003, 12'h300,    1, 8'h00, 16'h0303, "p1"};
        tbl[3]  = '{1'b0, 1'b1, 12'h003, 12'h300,   98, 8'h00, 16'h0597, "p99"};
        tbl[4]  = '{1'b0, 1'b1, 12'h003, 12'h300,    1, 8'h01, 16'h0600, "p100"};
        tbl[5]  = '{1'b0, 1'b1, 12'h003, 12'h300,  900, 8'h10, 16'h3300, "p1000"};
        tbl[6]  = '{1'b0, 1'b1, 12'h003, 12'h300, 2233, 8'h32, 16'h9999, "p3233"};
        tbl[7]  = '{1'b0, 1'b1, 12'h003, 12'h300,    1, 8'h32, 16'h9999, "p3234"};
        tbl[8]  = '{1'b0, 1'b1, 12'h003, 12'h300,   66, 8'h33, 16'h9999, "p3300"};
        tbl[9]  = '{1'b0, 1'b1, 12'h003, 12'h300, 6600, 8'h99, 16'h9999, "p9900"};
        tbl[10] = '{1'b0, 1'b1, 12'h003, 12'h300, 1000, 8'h99, 16'h9999, "full_hold"};
        tbl[11] = '{1'b1, 1'b1, 12'h999, 12'h001,    0, 8'h00, 16'h0001, "rst_b"};
        tbl[12] = '{1'b0, 1'b1, 12'h999, 12'h001,    1, 8'h00, 16'h1000, "carry1"};
        tbl[13] = '{1'b0, 1'b1, 12'h999, 12'h001,    9, 8'h00, 16'h9991, "carry10"};
        tbl[14] = '{1'b0, 1'b1, 12'h999, 12'h001,    1, 8'h00, 16'h9999, "acc_sat"};
        tbl[15] = '{1'b1, 1'b0, 12'h000, 12'h500,    0, 8'h00, 16'h0500, "rst_c"};
        tbl[16] = '{1'b0, 1'b1, 12'h000, 12'h500,  100, 8'h01, 16'h0500, "zero_rate"};
        tbl[17] = '{1'b0, 1'b1, 12'h000, 12'h999,    0, 8'h01, 16'h0999, "sfare_comb"};
        tbl[18] = '{1'b0, 1'b1, 12'h001, 12'h999,    1, 8'h01, 16'h1000, "out_carry"};

        for (int unsigned i = 0; i < NVEC; i++) begin
            distance_fare_per_pulse = tbl[i].per;
            s_fare = tbl[i].sf;
            en = tbl[i].en;
            rst_n = tbl[i].do_rst ? 1'b0 : 1'b1;
            expect_now(tbl[i].d, tbl[i].f, tbl[i].name);
            #2;
            pulse(tbl[i].n);
            #2;
            check_next();
        end

        // Asynchronous reset between edges, then recount from zero.
        rst_n = 1'b0;
        distance_fare_per_pulse = 12'h003;
        s_fare = 12'h300;
        en = 1'b1;
        #2 rst_n = 1'b1;
        #2;
        expect_now(8'h45, 16'h9999, "run4500");
        pulse(4500);
        #2 check_next();
        expect_now(8'h00, 16'h0300, "async_rst");
        rst_n = 1'b0;
        #1 check_next();
        #2 rst_n = 1'b1;
        #2;
        expect_now(8'h01, 16'h0600, "after_rst");
        pulse(100);
        #2 check_next();

        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
